// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser and a free-running 16x oversample tick.
// Presents each correctly framed byte with a 1-clk rx_done pulse; bad stop bits pulse frame_err.
module uart_rx #(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned SYS_CLK    = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TICK_DIV   = SYS_CLK / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MID_TICK  = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_TICK = OVERSAMPLE - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       TC_MID   = 4'(MID_TICK);
  localparam logic [3:0]       TC_LAST  = 4'(LAST_TICK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_p;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_done;
  logic             r_busy;
  logic             r_ferr;

  logic w_fall;
  logic w_tick;

  // Synchroniser; flops preset to idle-high so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_p    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_p    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_p & ~r_rx_s;

  // Free-running oversample divider, independent of frame timing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_tick_cnt <= 4'd0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tick_cnt == TC_MID) begin
              if (!r_rx_s) begin
                r_state    <= S_DATA;
                r_tick_cnt <= 4'd0;
                r_bit_cnt  <= 3'd0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == TC_LAST) begin
              r_shift    <= {r_rx_s, r_shift[7:1]};
              r_tick_cnt <= 4'd0;
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          // Return to IDLE at mid-stop so a back-to-back start edge is not missed
          if (w_tick) begin
            if (r_tick_cnt == TC_LAST) begin
              if (r_rx_s) begin
                r_data <= r_shift;
                r_done <= 1'b1;
              end else begin
                r_ferr <= 1'b1;
              end
              r_state    <= S_IDLE;
              r_tick_cnt <= 4'd0;
              r_busy     <= 1'b0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a serial driver queues expected frame outcomes,
// a monitor pops them whenever rx_done or frame_err fires.
module tb_uart_rx;

  localparam int unsigned TD      = 4;
  localparam int unsigned BIT     = 16 * TD;
  localparam int unsigned CLK_NS  = 10;
  localparam int unsigned LAT_MIN = 151 * TD;
  localparam int unsigned LAT_MAX = 153 * TD + 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     t0;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference: a frame ends in rx_done with its byte when the stop bit is high,
  // otherwise in frame_err with the last good byte still on rx_data.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit track);
    exp_t e;
    @(negedge clk);
    if (track) begin
      e.is_err = !stop_ok;
      e.data   = stop_ok ? b : last_good;
      e.t0     = longint'($time);
      sb.push_back(e);
      if (stop_ok) last_good = b;
    end
    rx = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = b[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = stop_ok;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   int'(rx_data),   0);
    check({tag, "_rx_done"},   int'(rx_done),   0);
    check({tag, "_rx_busy"},   int'(rx_busy),   0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Monitor: every output event must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    longint lat;
    if (rst && (rx_done || frame_err)) begin
      if (rx_done && frame_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_err_exclusive: both high at %0t", $time);
      end else if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: done=%0b err=%0b data=0x%0h, expected none at %0t",
                 rx_done, frame_err, rx_data, $time);
      end else begin
        e = sb.pop_front();
        check("event_is_err", int'(frame_err), int'(e.is_err));
        check("rx_data", int'(rx_data), int'(e.data));
        lat = (longint'($time) - e.t0) / CLK_NS;
        check_range("latency_clks", int'(lat), LAT_MIN, LAT_MAX);
      end
    end
  end

  initial begin
    #(70_000 * CLK_NS);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int waited;
    logic [7:0] b;
    bit ok;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    idle_bits(2);
    check("idle_busy_after_por", int'(rx_busy), 0);

    // Single frame
    send_frame(8'h30, 1'b1, 1'b1);
    idle_bits(2);
    check("idle_busy_after_30", int'(rx_busy), 0);

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    idle_bits(2);

    // Short low glitch: rejected in START after about 8 ticks of busy
    @(negedge clk);
    rx = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20 * TD; i++) begin
      @(negedge clk);
      if (i == 3 * TD - 1) rx = 1'b1;
      busy_cnt += int'(rx_busy);
    end
    check_range("glitch_busy_clks", busy_cnt, 7 * TD, 9 * TD + 2);
    idle_bits(1);

    // Framing error, then a held-low line that must not start frames
    send_frame(8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    check("break_busy", int'(rx_busy), 0);
    idle_bits(2);
    send_frame(8'h12, 1'b1, 1'b1);
    idle_bits(2);

    // Reset during data bit 4 of 0xA5 (line low there) discards the frame
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_outputs("midframe_rst");
        check("midframe_rx_low", int'(rx), 0);
        last_good = 8'h00;
      end
    join
    idle_bits(1);
    rst = 1'b1;
    idle_bits(2);
    check("idle_busy_after_rst", int'(rx_busy), 0);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h30, 1'b1, 1'b1);
    idle_bits(1);

    // Random frames, occasional bad stop bit, random gaps (0 allowed after good stops)
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, 1'b1);
      if (!ok || $urandom_range(0, 2) != 0) idle_bits(int'($urandom_range(1, 3)));
    end
    idle_bits(1);

    waited = 0;
    while (sb.size() != 0 && waited < 200 * TD) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
